// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BURST = 2'd2
  } arb_state_t;

  // Beat counter must be able to hold MAX_BURST itself, not just MAX_BURST-1.
  function automatic int beat_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request strictly after i_last, wrapping around.
module rr_pick #(
  parameter  int NUM_REQ   = 4,
  localparam int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [IDX_WIDTH-1:0] i_last,
  output logic [IDX_WIDTH-1:0] o_idx,
  output logic                 o_any
);

  localparam int PW = IDX_WIDTH + 1;

  logic [PW-1:0] w_pos;

  // Scan from farthest to nearest so the nearest candidate after i_last overwrites the rest.
  always_comb begin
    o_idx = '0;
    o_any = |i_req;
    w_pos = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_pos = {1'b0, i_last} + PW'(k);
      if (w_pos >= PW'(NUM_REQ)) begin
        w_pos = w_pos - PW'(NUM_REQ);
      end
      if (i_req[w_pos[IDX_WIDTH-1:0]]) begin
        o_idx = w_pos[IDX_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one async FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int IDX_WIDTH  = $clog2(NUM_REQ),
  localparam int CNT_WIDTH  = beat_cnt_width(MAX_BURST)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [IDX_WIDTH-1:0]          grant_idx,
  output logic                          busy,
  output logic [1:0]                    dbg_state,
  output logic [CNT_WIDTH-1:0]          dbg_beat_cnt
);

  arb_state_t           r_state;
  logic [IDX_WIDTH-1:0] r_grant_idx;
  logic [IDX_WIDTH-1:0] r_rr_last;
  logic [CNT_WIDTH-1:0] r_beat_cnt;
  logic                 r_busy;

  logic [IDX_WIDTH-1:0] w_winner;
  logic                 w_any;
  logic                 w_xfer;
  logic                 w_owner_valid;
  logic                 w_owner_last;
  logic                 w_accept;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 w_release;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req  (req_valid),
    .i_last (r_rr_last),
    .o_idx  (w_winner),
    .o_any  (w_any)
  );

  // Handshake: a beat moves when req_valid[i] && req_ready[i]; ready only ever goes to the
  // owner in BURST and only while the FIFO is not full, so winc mirrors exactly that transfer.
  assign w_xfer        = (r_state == BURST) && !rst;
  assign w_owner_valid = req_valid[r_grant_idx];
  assign w_owner_last  = req_last[r_grant_idx];
  assign w_accept      = w_xfer && w_owner_valid && !wfull;
  assign w_cnt_next    = r_beat_cnt + CNT_WIDTH'(1);

  // Cap and last-beat releases coincide harmlessly: both just end the burst this cycle.
  assign w_release = !w_owner_valid ||
                     (w_accept && (w_owner_last || (w_cnt_next == CNT_WIDTH'(MAX_BURST))));

  always_comb begin
    req_ready = '0;
    if (w_xfer && !wfull) begin
      req_ready[r_grant_idx] = 1'b1;
    end
  end

  assign winc         = w_accept;
  assign wdata        = req_data[r_grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign grant_idx    = r_grant_idx;
  assign busy         = r_busy;
  assign dbg_state    = r_state;
  assign dbg_beat_cnt = r_beat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_grant_idx <= '0;
      r_beat_cnt  <= '0;
      r_rr_last   <= IDX_WIDTH'(NUM_REQ - 1);
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant_idx <= w_winner;
            r_rr_last   <= w_winner;
            r_busy      <= 1'b1;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          r_beat_cnt <= '0;
          r_state    <= BURST;
        end
        BURST: begin
          if (w_accept) begin
            r_beat_cnt <= w_cnt_next;
          end
          if (w_release) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a cycle-level model.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic            wfull     = 1'b0;
  logic [N-1:0]    req_ready;
  logic            winc;
  logic [DW-1:0]   wdata;
  logic [1:0]      grant_idx;
  logic            busy;
  logic [1:0]      dbg_state;
  logic [2:0]      dbg_beat_cnt;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wfull        (wfull),
    .winc         (winc),
    .wdata        (wdata),
    .grant_idx    (grant_idx),
    .busy         (busy),
    .dbg_state    (dbg_state),
    .dbg_beat_cnt (dbg_beat_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  int n_winc  = 0;
  logic [DW-1:0] exp_q[$];
  int grant_q[$];
  int seen_q[$];
  logic prev_busy = 1'b0;

  // Reference model: owner (-1 = nobody), cycles still to wait before transfers,
  // beats taken this grant, and the most recently granted requester.
  int m_owner = -1;
  int m_wait  = 0;
  int m_beats = 0;
  int m_prev  = N - 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Evaluate one cycle mid-low-phase, then advance the model across the coming posedge.
  task automatic step();
    logic [N-1:0]  e_ready;
    logic          e_winc;
    logic          e_busy;
    logic          xfer;
    logic [1:0]    e_state;
    logic [DW-1:0] e_data;
    int            own;
    #1;
    own     = (m_owner < 0) ? 0 : m_owner;
    e_busy  = (m_owner >= 0);
    xfer    = !rst && (m_owner >= 0) && (m_wait == 0);
    e_ready = (xfer && !wfull) ? (N'(1) << own) : '0;
    e_winc  = xfer && req_valid[own] && !wfull;
    e_data  = req_data[own*DW +: DW];
    e_state = (m_owner < 0) ? IDLE : (m_wait > 0) ? GRANT : BURST;

    check("busy", busy, e_busy);
    check("state", dbg_state, e_state);
    check("winc", winc, e_winc);
    check("req_ready", req_ready, e_ready);
    check("no_bypass", winc & wfull, 0);
    if (e_busy) check("grant_idx", grant_idx, own);
    if (xfer) check("beat_cnt", dbg_beat_cnt, m_beats);

    if (e_winc) exp_q.push_back(e_data);
    if (winc) begin
      n_winc++;
      if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
      else check("wdata", wdata, exp_q.pop_front());
    end
    if (busy && !prev_busy) begin
      seen_q.push_back(int'(grant_idx));
      if (grant_q.size() == 0) check("grant_unexpected", 1, 0);
      else check("grant_order", grant_idx, grant_q.pop_front());
    end
    prev_busy = busy;

    if (rst) begin
      m_owner = -1; m_wait = 0; m_beats = 0; m_prev = N - 1;
    end else if (m_owner < 0) begin
      if (|req_valid) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_prev + k) % N;
          if (m_owner < 0 && req_valid[c]) m_owner = c;
        end
        m_prev  = m_owner;
        m_wait  = 1;
        m_beats = 0;
        grant_q.push_back(m_owner);
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else begin
      if (e_winc) m_beats++;
      if (!req_valid[own] || (e_winc && (req_last[own] || m_beats == MB))) m_owner = -1;
    end
    @(negedge clk);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input logic f, input logic r);
    rst       = r;
    req_valid = v;
    req_last  = l;
    wfull     = f;
    req_data  = $urandom;
    step();
  endtask

  task automatic go_idle();
    repeat (4) cycle('0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int n0;
    int exp_rr[5];
    exp_rr = '{0, 1, 2, 3, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);

    // 1: reset held with all requesters valid
    repeat (3) cycle(4'hF, 4'h0, 1'b0, 1'b1);
    check("t1_busy", busy, 0);
    check("t1_winc", winc, 0);
    check("t1_ready", req_ready, 0);

    // 2: round robin with single-beat bursts
    seen_q.delete();
    repeat (16) cycle(4'hF, 4'hF, 1'b0, 1'b0);
    check("t2_count_ok", seen_q.size() >= 5, 1);
    for (int i = 0; i < 5; i++) begin
      if (i < seen_q.size()) check("t2_rr", seen_q[i], exp_rr[i]);
    end

    // 3: burst cap on a lone requester
    go_idle();
    n0 = n_winc;
    repeat (6) cycle(4'b0100, 4'b0000, 1'b0, 1'b0);
    check("t3_beats", n_winc - n0, 4);
    check("t3_released", busy, 0);
    cycle(4'b0100, 4'b0000, 1'b0, 1'b0);
    check("t3_regrant_busy", busy, 1);
    check("t3_regrant_idx", grant_idx, 2);

    // 4: backpressure mid-burst
    go_idle();
    n0 = n_winc;
    guard = 0;
    while (!(m_owner == 1 && m_wait == 0 && m_beats == 1) && guard < 40) begin
      cycle(4'b0010, 4'b0000, 1'b0, 1'b0);
      guard++;
    end
    check("t4_reach", guard < 40, 1);
    repeat (5) begin
      cycle(4'b0010, 4'b0000, 1'b1, 1'b0);
      check("t4_hold_busy", busy, 1);
      check("t4_hold_idx", grant_idx, 1);
      check("t4_stall_ready", req_ready, 0);
      check("t4_stall_winc", winc, 0);
    end
    guard = 0;
    while (m_owner >= 0 && guard < 40) begin
      cycle(4'b0010, 4'b0000, 1'b0, 1'b0);
      guard++;
    end
    check("t4_done", guard < 40, 1);
    check("t4_beats", n_winc - n0, 4);

    // 5: owner drops valid while another waits
    go_idle();
    guard = 0;
    while (m_owner != 3 && guard < 40) begin
      cycle(4'b1000, 4'b0000, 1'b0, 1'b0);
      guard++;
    end
    guard = 0;
    while (!(m_owner == 3 && m_wait == 0 && m_beats == 2) && guard < 40) begin
      cycle(4'b1001, 4'b0000, 1'b0, 1'b0);
      guard++;
    end
    check("t5_reach", guard < 40, 1);
    cycle(4'b0001, 4'b0000, 1'b0, 1'b0);
    check("t5_released", busy, 0);
    cycle(4'b0001, 4'b0000, 1'b0, 1'b0);
    check("t5_next_busy", busy, 1);
    check("t5_next_idx", grant_idx, 0);

    // 6: reset on the second beat
    go_idle();
    guard = 0;
    while (!(m_owner == 2 && m_wait == 0 && m_beats == 1) && guard < 40) begin
      cycle(4'b0100, 4'b0000, 1'b0, 1'b0);
      guard++;
    end
    check("t6_reach", guard < 40, 1);
    n0 = n_winc;
    cycle(4'b0100, 4'b0000, 1'b0, 1'b1);
    check("t6_no_write", n_winc - n0, 0);
    check("t6_state", dbg_state, IDLE);
    check("t6_busy", busy, 0);
    cycle(4'hF, 4'h0, 1'b0, 1'b0);
    check("t6_next_idx", grant_idx, 0);
    check("t6_next_busy", busy, 1);

    // random traffic
    repeat (1500) begin
      logic [N-1:0] v;
      logic [N-1:0] l;
      v = N'($urandom);
      for (int i = 0; i < N; i++) l[i] = ($urandom_range(0, 3) == 0);
      cycle(v, l, $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0);
    end
    go_idle();
    check("end_exp_q", exp_q.size(), 0);
    check("end_grant_q", grant_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
